// File: rtl/alu_uart_tx_top.sv
// alu_uart_tx_top
//   Collects operand A, operand B and a MIPS-funct opcode, one byte per
//   write strobe. It computes the ALU result and sends the result byte as one
//   8N1 UART frame.
// Ports:
//   clock            system clock
//   reset            synchronous active-high reset
//   din              byte to load (A, then B, then opcode in low NB_OP bits)
//   wr               one-cycle write strobe qualifying din
//   tx               UART serial line, idles high
//   o_alu            registered ALU result
//   salida_operacion latched opcode
//   salida_A/B       latched operands
//   VER_ESTADOS      one-hot interface FSM state
//   CHECK_ENTRADA_TX byte loaded into the transmitter
module alu_uart_tx_top #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int BAUD_DIV = 163,
  parameter int SB_TICKS = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NB_DATA-1:0] din,
  input  logic               wr,
  output logic               tx,
  output logic [NB_DATA-1:0] o_alu,
  output logic [NB_OP-1:0]   salida_operacion,
  output logic [NB_DATA-1:0] salida_A,
  output logic [NB_DATA-1:0] salida_B,
  output logic [4:0]         VER_ESTADOS,
  output logic [NB_DATA-1:0] CHECK_ENTRADA_TX
);

  localparam int NB_BAUD = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int NB_SB   = (SB_TICKS > 1) ? $clog2(SB_TICKS) : 1;
  localparam int NB_BIT  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [NB_BAUD-1:0] BAUD_LAST = NB_BAUD'(BAUD_DIV - 1);
  localparam logic [NB_SB-1:0]   SB_LAST   = NB_SB'(SB_TICKS - 1);
  localparam logic [NB_BIT-1:0]  BIT_LAST  = NB_BIT'(NB_DATA - 1);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  typedef enum logic [4:0] {
    S_A    = 5'b00001,
    S_B    = 5'b00010,
    S_OP   = 5'b00100,
    S_EXEC = 5'b01000,
    S_TX   = 5'b10000
  } if_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  if_state_t           r_state;
  tx_state_t           r_tx_state;
  logic [NB_BAUD-1:0]  r_baud_cnt;
  logic [NB_DATA-1:0]  r_a, r_b, r_alu, r_check;
  logic [NB_OP-1:0]    r_op;
  logic [NB_SB-1:0]    r_s_cnt;
  logic [NB_BIT-1:0]   r_n;
  logic [NB_DATA-1:0]  r_shreg;
  logic                r_tx, r_tx_done;
  logic                w_tick, w_tx_start;
  logic [NB_DATA-1:0]  w_alu;

  // Baud tick generator
  assign w_tick = (r_baud_cnt == BAUD_LAST);

  always_ff @(posedge clock) begin
    if (reset)       r_baud_cnt <= '0;
    else if (w_tick) r_baud_cnt <= '0;
    else             r_baud_cnt <= r_baud_cnt + 1'b1;
  end

  // ALU on the latched registers
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_NOR:  w_alu = ~(r_a | r_b);
      OP_SRA:  w_alu = NB_DATA'($signed(r_a) >>> r_b);
      OP_SRL:  w_alu = r_a >> r_b;
      default: w_alu = '0;
    endcase
  end

  // The start request is decoded from S_EXEC so the transmitter loads the
  // same w_alu value that o_alu registers on that edge.
  assign w_tx_start = (r_state == S_EXEC);

  // Interface FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_alu   <= '0;
      r_check <= '0;
    end else begin
      case (r_state)
        S_A:    if (wr) begin r_a <= din; r_state <= S_B; end
        S_B:    if (wr) begin r_b <= din; r_state <= S_OP; end
        S_OP:   if (wr) begin r_op <= din[NB_OP-1:0]; r_state <= S_EXEC; end
        S_EXEC: begin
          r_alu   <= w_alu;
          r_check <= w_alu;
          r_state <= S_TX;
        end
        S_TX:    if (r_tx_done) r_state <= S_A;
        default: r_state <= S_A;
      endcase
    end
  end

  // UART TX FSM; tx is registered and driven low on the edge that enters START
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_s_cnt    <= '0;
      r_n        <= '0;
      r_shreg    <= '0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (w_tx_start) begin
            r_shreg    <= w_alu;
            r_s_cnt    <= '0;
            r_tx       <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: if (w_tick) begin
          if (r_s_cnt == SB_LAST) begin
            r_s_cnt    <= '0;
            r_n        <= '0;
            r_tx       <= r_shreg[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_s_cnt <= r_s_cnt + 1'b1;
          end
        end
        TX_DATA: if (w_tick) begin
          if (r_s_cnt == SB_LAST) begin
            r_s_cnt <= '0;
            r_shreg <= r_shreg >> 1;
            if (r_n == BIT_LAST) begin
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_n  <= r_n + 1'b1;
              r_tx <= r_shreg[1];
            end
          end else begin
            r_s_cnt <= r_s_cnt + 1'b1;
          end
        end
        TX_STOP: if (w_tick) begin
          if (r_s_cnt == SB_LAST) begin
            r_tx_done  <= 1'b1;
            r_tx_state <= TX_IDLE;
          end else begin
            r_s_cnt <= r_s_cnt + 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx               = r_tx;
  assign o_alu            = r_alu;
  assign salida_operacion = r_op;
  assign salida_A         = r_a;
  assign salida_B         = r_b;
  assign VER_ESTADOS      = r_state;
  assign CHECK_ENTRADA_TX = r_check;

endmodule

// File: tb/tb_alu_uart_tx_top.sv
module tb_alu_uart_tx_top;

  localparam int B  = 4;
  localparam int SB = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       wr;
  logic       tx;
  logic [7:0] o_alu;
  logic [5:0] salida_operacion;
  logic [7:0] salida_A, salida_B;
  logic [4:0] VER_ESTADOS;
  logic [7:0] CHECK_ENTRADA_TX;

  alu_uart_tx_top #(
    .NB_DATA(8),
    .NB_OP(6),
    .BAUD_DIV(B),
    .SB_TICKS(SB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .din(din),
    .wr(wr),
    .tx(tx),
    .o_alu(o_alu),
    .salida_operacion(salida_operacion),
    .salida_A(salida_A),
    .salida_B(salida_B),
    .VER_ESTADOS(VER_ESTADOS),
    .CHECK_ENTRADA_TX(CHECK_ENTRADA_TX)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] exp;
    bit         noise;
  } vec_t;

  vec_t       tbl[11];
  logic [7:0] sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] d);
    din = d;
    wr  = 1'b1;
    @(posedge clock); #1;
    wr  = 1'b0;
  endtask

  // Samples each bit at its centre, measured from the edge where tx fell.
  // With noise set, a write strobe is injected during the frame.
  task automatic rx_frame(input bit noise, output logic [9:0] frame);
    int cyc;
    int target;
    cyc = 0;
    frame = '0;
    for (int i = 0; i < 10; i++) begin
      target = SB * B * i + (SB * B) / 2;
      repeat (target - cyc) @(posedge clock);
      #1;
      cyc = target;
      frame[i] = tx;
      if (noise && (i == 3 || i == 6)) begin
        din = 8'hAA;
        wr  = 1'b1;
        @(posedge clock); #1;
        wr  = 1'b0;
        cyc++;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [9:0] frame;
    logic [7:0] exp_b;
    bit         seen;
    wr_byte(v.a);
    wr_byte(v.b);
    wr_byte({2'b00, v.op});
    sb_q.push_back(v.exp);
    chk({tag, ".A"}, 32'(salida_A), 32'(v.a));
    chk({tag, ".B"}, 32'(salida_B), 32'(v.b));
    chk({tag, ".op"}, 32'(salida_operacion), 32'(v.op));
    chk({tag, ".st_exec"}, 32'(VER_ESTADOS), 32'(5'b01000));
    @(posedge clock); #1;
    chk({tag, ".st_tx"}, 32'(VER_ESTADOS), 32'(5'b10000));
    chk({tag, ".o_alu"}, 32'(o_alu), 32'(v.exp));
    chk({tag, ".check_tx"}, 32'(CHECK_ENTRADA_TX), 32'(v.exp));
    rx_frame(v.noise, frame);
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      exp_b = '0;
    end else begin
      exp_b = sb_q.pop_front();
    end
    chk({tag, ".frame"}, 32'(frame), 32'({1'b1, exp_b, 1'b0}));
    seen = 1'b0;
    for (int c = 0; c < 20 * B; c++) begin
      @(posedge clock); #1;
      if (VER_ESTADOS == 5'b00001) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, ".back_to_S_A"}, 32'(seen), 32'd1);
    if (v.noise) begin
      chk({tag, ".A_kept"}, 32'(salida_A), 32'(v.a));
      chk({tag, ".B_kept"}, 32'(salida_B), 32'(v.b));
      chk({tag, ".op_kept"}, 32'(salida_operacion), 32'(v.op));
    end
  endtask

  initial begin
    vec_t rv;
    tbl[0]  = '{8'h03, 8'h02, 6'h20, 8'h05, 1'b0};  // ADD
    tbl[1]  = '{8'h03, 8'h02, 6'h24, 8'h02, 1'b0};  // AND
    tbl[2]  = '{8'hFF, 8'h01, 6'h20, 8'h00, 1'b0};  // ADD wrap
    tbl[3]  = '{8'h02, 8'h03, 6'h22, 8'hFF, 1'b0};  // SUB wrap
    tbl[4]  = '{8'h80, 8'h01, 6'h03, 8'hC0, 1'b0};  // SRA
    tbl[5]  = '{8'h80, 8'h01, 6'h02, 8'h40, 1'b0};  // SRL
    tbl[6]  = '{8'h5A, 8'h0F, 6'h25, 8'h5F, 1'b0};  // OR
    tbl[7]  = '{8'h5A, 8'h0F, 6'h26, 8'h55, 1'b1};  // XOR, wr noise in S_TX
    tbl[8]  = '{8'h5A, 8'h0F, 6'h27, 8'hA0, 1'b0};  // NOR
    tbl[9]  = '{8'h12, 8'h34, 6'h3F, 8'h00, 1'b0};  // undefined opcode
    tbl[10] = '{8'hC3, 8'h02, 6'h03, 8'hF0, 1'b1};  // SRA by 2, wr noise

    reset = 1'b1;
    wr    = 1'b0;
    din   = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst.tx", 32'(tx), 32'd1);
    chk("rst.state", 32'(VER_ESTADOS), 32'(5'b00001));
    chk("rst.o_alu", 32'(o_alu), 32'd0);
    chk("rst.A", 32'(salida_A), 32'd0);
    chk("rst.B", 32'(salida_B), 32'd0);
    chk("rst.op", 32'(salida_operacion), 32'd0);
    chk("rst.check_tx", 32'(CHECK_ENTRADA_TX), 32'd0);

    // Without wr the interface FSM holds in S_A
    repeat (5) @(posedge clock);
    #1;
    chk("idle.hold", 32'(VER_ESTADOS), 32'(5'b00001));

    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i));
    end

    // Reset during data bits of an all-zero frame
    wr_byte(8'h00);
    wr_byte(8'h00);
    wr_byte(8'h20);
    sb_q.push_back(8'h00);
    @(posedge clock); #1;
    repeat (SB * B * 3 + (SB * B) / 2) @(posedge clock);
    #1;
    chk("midrst.tx_low", 32'(tx), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst.tx", 32'(tx), 32'd1);
    chk("midrst.state", 32'(VER_ESTADOS), 32'(5'b00001));
    chk("midrst.o_alu", 32'(o_alu), 32'd0);
    reset = 1'b0;
    sb_q.delete();
    repeat (SB * B) @(posedge clock);
    #1;
    chk("midrst.tx_idle", 32'(tx), 32'd1);
    rv = '{8'h03, 8'h02, 6'h20, 8'h05, 1'b0};
    run_vec(rv, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
